// File: rtl/spi_command_master.sv
// rtl/spi_command_master.sv - queued SPI mode-0 command master; optional SPI_TRIGGER_AFTER_LAST_EN
module spi_command_master #(
  parameter int CLK_DIV         = 2,
  parameter int WORD_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int FIFO_ADDR_WIDTH = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [WORD_WIDTH-1:0] cmd_data,
  input  logic                  cmd_valid,
`ifdef SPI_TRIGGER_AFTER_LAST_EN
  input  logic                  cmd_last,
  output logic                  control_trigger,
`endif
  output logic                  cmd_ready,
  output logic [WORD_WIDTH-1:0] rsp_data,
  output logic                  rsp_valid,
  output logic                  busy,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  ss_n,
  input  logic                  miso,
  output logic                  latch_data
);

`ifdef SPI_TRIGGER_AFTER_LAST_EN
  localparam int LP_FW = WORD_WIDTH + 1;
`else
  localparam int LP_FW = WORD_WIDTH;
`endif
  localparam int LP_CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LP_BW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [LP_CW-1:0] LP_HALF = LP_CW'(CLK_DIV - 1);
  localparam logic [LP_BW-1:0] LP_LAST_BIT = LP_BW'(WORD_WIDTH - 1);
  localparam logic [FIFO_ADDR_WIDTH:0] LP_DEPTH = (FIFO_ADDR_WIDTH + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_LATCH,
    ST_GAP
  } state_t;

  // command queue storage
  logic [LP_FW-1:0]           r_mem [FIFO_DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] r_wr_ptr;
  logic [FIFO_ADDR_WIDTH-1:0] r_rd_ptr;
  logic [FIFO_ADDR_WIDTH:0]   r_count;
  logic                       w_full;
  logic                       w_empty;
  logic                       w_push;
  logic                       w_pop;
  logic [LP_FW-1:0]           w_wr_word;
  logic [LP_FW-1:0]           w_rd_word;

  // shift engine state
  state_t                  r_state;
  state_t                  w_state_next;
  logic [LP_CW-1:0]        r_half_cnt;
  logic [LP_CW-1:0]        w_half_cnt_next;
  logic [LP_BW-1:0]        r_bit_cnt;
  logic [LP_BW-1:0]        w_bit_cnt_next;
  logic [WORD_WIDTH-1:0]   r_tx;
  logic [WORD_WIDTH-1:0]   w_tx_next;
  logic [WORD_WIDTH-1:0]   r_rx;
  logic [WORD_WIDTH-1:0]   w_rx_next;
  logic [WORD_WIDTH-1:0]   r_rsp_data;
  logic [WORD_WIDTH-1:0]   w_rsp_data_next;
  logic                    r_sclk;
  logic                    w_sclk_next;
  logic                    r_mosi;
  logic                    w_mosi_next;
  logic                    r_ss_n;
  logic                    w_ss_n_next;
  logic                    r_latch;
  logic                    w_latch_next;
  logic                    r_rsp_valid;
  logic                    w_rsp_valid_next;
  logic                    w_load;
`ifdef SPI_TRIGGER_AFTER_LAST_EN
  logic                    r_last;
  logic                    w_last_next;
  logic                    r_trigger;
  logic                    w_trigger_next;
`endif

`ifdef SPI_TRIGGER_AFTER_LAST_EN
  assign w_wr_word = {cmd_last, cmd_data};
`else
  assign w_wr_word = cmd_data;
`endif
  assign w_rd_word = r_mem[r_rd_ptr];
  assign w_full    = (r_count == LP_DEPTH);
  assign w_empty   = (r_count == '0);
  assign w_push    = cmd_valid && !w_full;
  assign cmd_ready = !w_full;

  // queue payload write; contents need no reset because the count gates reads
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_word;
    end
  end

  // queue pointers and occupancy; pointers wrap naturally at the power-of-2 depth
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // next-state and next-output logic; GAP reloads directly so deselect is 1+CLK_DIV cycles
  always_comb begin
    w_state_next     = r_state;
    w_half_cnt_next  = r_half_cnt;
    w_bit_cnt_next   = r_bit_cnt;
    w_tx_next        = r_tx;
    w_rx_next        = r_rx;
    w_rsp_data_next  = r_rsp_data;
    w_sclk_next      = r_sclk;
    w_mosi_next      = r_mosi;
    w_ss_n_next      = r_ss_n;
    w_latch_next     = 1'b0;
    w_rsp_valid_next = 1'b0;
    w_load           = 1'b0;
    w_pop            = 1'b0;
`ifdef SPI_TRIGGER_AFTER_LAST_EN
    w_last_next      = r_last;
    w_trigger_next   = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) w_load = 1'b1;
      end
      ST_SETUP: begin
        if (r_half_cnt == '0) begin
          w_state_next    = ST_HIGH;
          w_half_cnt_next = LP_HALF;
          w_sclk_next     = 1'b1;
          w_rx_next       = {r_rx[WORD_WIDTH-2:0], miso};
        end else begin
          w_half_cnt_next = r_half_cnt - 1'b1;
        end
      end
      ST_HIGH: begin
        if (r_half_cnt == '0) begin
          w_state_next    = ST_LOW;
          w_half_cnt_next = LP_HALF;
          w_sclk_next     = 1'b0;
          if (r_bit_cnt != '0) begin
            w_mosi_next = r_tx[WORD_WIDTH-2];
            w_tx_next   = {r_tx[WORD_WIDTH-2:0], 1'b0};
          end
        end else begin
          w_half_cnt_next = r_half_cnt - 1'b1;
        end
      end
      ST_LOW: begin
        if (r_half_cnt == '0) begin
          if (r_bit_cnt != '0) begin
            w_state_next    = ST_HIGH;
            w_half_cnt_next = LP_HALF;
            w_bit_cnt_next  = r_bit_cnt - 1'b1;
            w_sclk_next     = 1'b1;
            w_rx_next       = {r_rx[WORD_WIDTH-2:0], miso};
          end else begin
            w_state_next     = ST_LATCH;
            w_ss_n_next      = 1'b1;
            w_mosi_next      = 1'b0;
            w_latch_next     = 1'b1;
            w_rsp_valid_next = 1'b1;
            w_rsp_data_next  = r_rx;
          end
        end else begin
          w_half_cnt_next = r_half_cnt - 1'b1;
        end
      end
      ST_LATCH: begin
        w_state_next    = ST_GAP;
        w_half_cnt_next = LP_HALF;
`ifdef SPI_TRIGGER_AFTER_LAST_EN
        w_trigger_next  = r_last;
`endif
      end
      ST_GAP: begin
        if (r_half_cnt == '0) begin
          if (!w_empty) w_load = 1'b1;
          else          w_state_next = ST_IDLE;
        end else begin
          w_half_cnt_next = r_half_cnt - 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    if (w_load) begin
      w_pop           = 1'b1;
      w_state_next    = ST_SETUP;
      w_half_cnt_next = LP_HALF;
      w_bit_cnt_next  = LP_LAST_BIT;
      w_tx_next       = w_rd_word[WORD_WIDTH-1:0];
      w_mosi_next     = w_rd_word[WORD_WIDTH-1];
      w_rx_next       = '0;
      w_ss_n_next     = 1'b0;
      w_sclk_next     = 1'b0;
`ifdef SPI_TRIGGER_AFTER_LAST_EN
      w_last_next     = w_rd_word[WORD_WIDTH];
`endif
    end
  end

  // state and registered SPI/handshake outputs; reset aborts any word in flight
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_half_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_rsp_data  <= '0;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
      r_ss_n      <= 1'b1;
      r_latch     <= 1'b0;
      r_rsp_valid <= 1'b0;
`ifdef SPI_TRIGGER_AFTER_LAST_EN
      r_last      <= 1'b0;
      r_trigger   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_half_cnt  <= w_half_cnt_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_tx        <= w_tx_next;
      r_rx        <= w_rx_next;
      r_rsp_data  <= w_rsp_data_next;
      r_sclk      <= w_sclk_next;
      r_mosi      <= w_mosi_next;
      r_ss_n      <= w_ss_n_next;
      r_latch     <= w_latch_next;
      r_rsp_valid <= w_rsp_valid_next;
`ifdef SPI_TRIGGER_AFTER_LAST_EN
      r_last      <= w_last_next;
      r_trigger   <= w_trigger_next;
`endif
    end
  end

  assign sclk       = r_sclk;
  assign mosi       = r_mosi;
  assign ss_n       = r_ss_n;
  assign latch_data = r_latch;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign busy       = !w_empty || (r_state != ST_IDLE);
`ifdef SPI_TRIGGER_AFTER_LAST_EN
  assign control_trigger = r_trigger;
`endif

endmodule

// File: tb/tb_spi_command_master.sv
// tb/tb_spi_command_master.sv - scoreboard bench for spi_command_master
module tb_spi_command_master;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] cmd_data = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_last = 1'b0;
  logic        cmd_ready, rsp_valid, busy, sclk, mosi, ss_n, miso, latch_data;
  logic [31:0] rsp_data;
  logic        control_trigger;

  logic [31:0] cmd_data1 = '0;
  logic        cmd_valid1 = 1'b0;
  logic        cmd_last1 = 1'b0;
  logic        cmd_ready1, rsp_valid1, busy1, sclk1, mosi1, ss_n1, latch1;
  logic [31:0] rsp_data1;
  logic        control_trigger1;

  always #5 clock = ~clock;

  spi_command_master #(.CLK_DIV(2), .WORD_WIDTH(32), .FIFO_DEPTH(4), .FIFO_ADDR_WIDTH(2)) u_dut (
    .clock(clock), .reset_n(reset_n), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
`ifdef SPI_TRIGGER_AFTER_LAST_EN
    .cmd_last(cmd_last), .control_trigger(control_trigger),
`endif
    .cmd_ready(cmd_ready), .rsp_data(rsp_data), .rsp_valid(rsp_valid), .busy(busy),
    .sclk(sclk), .mosi(mosi), .ss_n(ss_n), .miso(miso), .latch_data(latch_data)
  );

  spi_command_master #(.CLK_DIV(1), .WORD_WIDTH(32), .FIFO_DEPTH(4), .FIFO_ADDR_WIDTH(2)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .cmd_data(cmd_data1), .cmd_valid(cmd_valid1),
`ifdef SPI_TRIGGER_AFTER_LAST_EN
    .cmd_last(cmd_last1), .control_trigger(control_trigger1),
`endif
    .cmd_ready(cmd_ready1), .rsp_data(rsp_data1), .rsp_valid(rsp_valid1), .busy(busy1),
    .sclk(sclk1), .mosi(mosi1), .ss_n(ss_n1), .miso(1'b0), .latch_data(latch1)
  );

`ifndef SPI_TRIGGER_AFTER_LAST_EN
  assign control_trigger  = 1'b0;
  assign control_trigger1 = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_tx_q[$];
  logic [31:0] exp_rsp_q[$];
  logic [31:0] slave_q[$];
  int          gaps_q[$];

  // SPI slave: loads its response at chip-select fall, shifts on falling sclk
  logic [31:0] slave_sreg = '0;
  assign miso = slave_sreg[31];
  always @(negedge ss_n) begin
    if (slave_q.size() > 0) slave_sreg <= slave_q.pop_front();
    else                    slave_sreg <= '0;
  end
  always @(negedge sclk) slave_sreg <= slave_sreg << 1;

  // monitor state
  logic        mon_en = 1'b0;
  logic        abort = 1'b0;
  logic        prev_ss = 1'b1, prev_sclk = 1'b0, prev_latch = 1'b0, prev_rspv = 1'b0;
  int          mon_low = 0, mon_rises = 0, hi_run = 0;
  logic [31:0] mon_word = '0;
  int          latch_cnt = 0, rspv_cnt = 0, viol = 0, trig_cnt = 0, trig_latch_idx = 0;

  // bus monitor sampled on the falling clock edge
  initial begin
    forever begin
      @(negedge clock);
      if (mon_en) begin
        if (!ss_n) begin
          if (prev_ss) begin
            mon_low = 0;
            mon_rises = 0;
            mon_word = '0;
            gaps_q.push_back(hi_run);
          end
          mon_low++;
          if (sclk && !prev_sclk) begin
            mon_rises++;
            mon_word = {mon_word[30:0], mosi};
          end
          hi_run = 0;
        end else begin
          hi_run++;
          if (!prev_ss) begin
            if (abort) abort = 1'b0;
            else begin
              if (exp_tx_q.size() == 0) check_eq("tx_unexpected", 1, 0);
              else check_eq("tx_word", mon_word, exp_tx_q.pop_front());
              check_eq("ss_low_len", mon_low, 130);
              check_eq("sclk_rises", mon_rises, 32);
            end
          end
        end
        if (latch_data) begin
          latch_cnt++;
          if (!ss_n || prev_latch) viol++;
          check_eq("latch_with_rsp", {31'b0, rsp_valid}, 1);
          check_eq("latch_follows_ss", {31'b0, prev_ss}, 0);
        end
        if (rsp_valid) begin
          rspv_cnt++;
          if (prev_rspv) viol++;
          if (exp_rsp_q.size() == 0) check_eq("rsp_unexpected", 1, 0);
          else check_eq("rsp_data", rsp_data, exp_rsp_q.pop_front());
        end
        if (control_trigger) begin
          trig_cnt++;
          trig_latch_idx = latch_cnt;
          check_eq("trig_after_latch", {31'b0, prev_latch}, 1);
        end
        prev_ss    = ss_n;
        prev_sclk  = sclk;
        prev_latch = latch_data;
        prev_rspv  = rsp_valid;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input logic [31:0] data, input logic [31:0] rsp, input logic last);
    logic ok;
    logic done;
    done = 1'b0;
    exp_tx_q.push_back(data);
    exp_rsp_q.push_back(rsp);
    slave_q.push_back(rsp);
    cmd_data  = data;
    cmd_last  = last;
    cmd_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      ok = cmd_ready;
      tick();
      if (ok) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check_eq("push_timeout", 0, 1);
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      if (!busy) break;
      tick();
    end
    if (busy) check_eq("idle_timeout", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, base_latch, base_rspv, base_trig, low, bad_mosi, bad_tog, rises, rsp_seen;
    logic seen, p;
    logic [31:0] rsp_d;
    logic found;

    // reset state
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    mon_en = 1'b1;
    check_eq("rst_sclk", {31'b0, sclk}, 0);
    check_eq("rst_mosi", {31'b0, mosi}, 0);
    check_eq("rst_ss_n", {31'b0, ss_n}, 1);
    check_eq("rst_latch", {31'b0, latch_data}, 0);
    check_eq("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    check_eq("rst_rsp_data", rsp_data, 0);
    check_eq("rst_busy", {31'b0, busy}, 0);
    check_eq("rst_cmd_ready", {31'b0, cmd_ready}, 1);
    check_eq("rst_ss_n_div1", {31'b0, ss_n1}, 1);

    // single word, miso low
    push_word(32'hA5C3_0F81, 32'h0, 1'b0);
    wait_idle();
    check_eq("t1_latch_count", latch_cnt, 1);

    // response capture
    push_word(32'h0BAD_F00D, 32'h1234_5678, 1'b0);
    wait_idle();
    check_eq("t2_rsp_count", rspv_cnt, 2);

    // five back-to-back words into a depth-4 queue
    gaps_q.delete();
    for (int i = 0; i < 5; i++) begin
      push_word(32'h1111_1111 * (i + 1) ^ 32'h8000_0003, 32'hF0E1_D2C3 ^ (32'h0101_0101 << i), 1'b0);
    end
    check_eq("ready_full", {31'b0, cmd_ready}, 0);
    for (int i = 0; i < 500 && !ss_n; i++) tick();
    for (int i = 0; i < 500 && ss_n; i++) tick();
    check_eq("ready_recover", {31'b0, cmd_ready}, 1);
    hi = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (ss_n) hi++;
      else hi = 0;
      if (!busy) break;
    end
    check_eq("busy_fall_after_gap", hi, 4);
    check_eq("t3_all_sent", exp_tx_q.size(), 0);
    check_eq("gap_count", gaps_q.size(), 5);
    if (gaps_q.size() == 5) begin
      for (int i = 1; i < 5; i++) check_eq("gap_len", gaps_q[i], 3);
    end

    // reset in the middle of bit 17
    push_word(32'hC0FF_EE11, 32'hDEAD_BEEF, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!ss_n && mon_rises == 17) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check_eq("reach_bit17", {31'b0, found}, 1);
    base_latch = latch_cnt;
    base_rspv  = rspv_cnt;
    abort = 1'b1;
    void'(exp_tx_q.pop_back());
    void'(exp_rsp_q.pop_back());
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_eq("abort_ss_n", {31'b0, ss_n}, 1);
    check_eq("abort_sclk", {31'b0, sclk}, 0);
    check_eq("abort_mosi", {31'b0, mosi}, 0);
    check_eq("abort_busy", {31'b0, busy}, 0);
    check_eq("abort_ready", {31'b0, cmd_ready}, 1);
    repeat (20) tick();
    check_eq("abort_no_latch", latch_cnt, base_latch);
    check_eq("abort_no_rsp", rspv_cnt, base_rspv);
    push_word(32'h5A5A_0001, 32'h8765_4321, 1'b0);
    wait_idle();

    // CLK_DIV=1 instance
    cmd_data1 = 32'hFFFF_FFFF;
    cmd_valid1 = 1'b1;
    tick();
    cmd_valid1 = 1'b0;
    low = 0; bad_mosi = 0; bad_tog = 0; rises = 0; rsp_seen = 0; rsp_d = 32'hFFFF_FFFF;
    seen = 1'b0; p = sclk1;
    for (int i = 0; i < 300; i++) begin
      if (!ss_n1) begin
        low++;
        seen = 1'b1;
        if (!mosi1) bad_mosi++;
        if (low == 1 && sclk1) bad_tog++;
        if (low > 1 && sclk1 == p) bad_tog++;
        if (sclk1 && !p) rises++;
      end
      if (rsp_valid1) begin
        rsp_seen++;
        rsp_d = rsp_data1;
      end
      p = sclk1;
      if (seen && !busy1) break;
      tick();
    end
    check_eq("d1_ss_low_len", low, 65);
    check_eq("d1_mosi_high", bad_mosi, 0);
    check_eq("d1_sclk_toggle", bad_tog, 0);
    check_eq("d1_rises", rises, 32);
    check_eq("d1_rsp_count", rsp_seen, 1);
    check_eq("d1_rsp_data", rsp_d, 0);
    check_eq("d1_idle", {31'b0, busy1}, 0);

`ifdef SPI_TRIGGER_AFTER_LAST_EN
    // trigger after the last word of a burst
    base_trig  = trig_cnt;
    base_latch = latch_cnt;
    push_word(32'h0000_0101, 32'h0, 1'b0);
    push_word(32'h0000_0202, 32'h0, 1'b0);
    push_word(32'h0000_0303, 32'h0, 1'b1);
    wait_idle();
    repeat (4) tick();
    check_eq("trig_count", trig_cnt - base_trig, 1);
    check_eq("trig_after_third", trig_latch_idx, base_latch + 3);
`else
    base_trig = trig_cnt;
    check_eq("no_trigger", base_trig, 0);
`endif

    repeat (5) tick();
    check_eq("invariants", viol, 0);
    check_eq("tx_queue_empty", exp_tx_q.size(), 0);
    check_eq("rsp_queue_empty", exp_rsp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_command_master.md
Name: spi_command_master

Overview:
Host-side SPI initiator that drives the sequencer chip's command port. It queues 32-bit command words, shifts each one out MSB-first on sclk/mosi/ss_n in SPI mode 0, and captures miso into a response word. After each word it deasserts ss_n and pulses latch_data, so the chip's system_controller consumes the word. It sits in the bring-up/test harness and in any companion controller that configures dot_sequencer memories and cycle timing.

Parameters:
- CLK_DIV, 2, clock cycles per sclk half-period; legal values are 1 and above.
- WORD_WIDTH, 32, bits per SPI transaction.
- FIFO_DEPTH, 4, depth of the command queue; must be a power of 2.
- FIFO_ADDR_WIDTH, 2, log2(FIFO_DEPTH).

Ports:
- clock, input, 1, system clock; all logic is on the rising edge.
- reset_n, input, 1, synchronous active-low reset.
- cmd_data, input, WORD_WIDTH, command word to queue.
- cmd_valid, input, 1, push request.
- cmd_ready, output, 1, queue not full; a push occurs when cmd_valid && cmd_ready.
- rsp_data, output, WORD_WIDTH, miso word captured during the last transaction.
- rsp_valid, output, 1, one-cycle strobe; rsp_data is valid in this cycle.
- busy, output, 1, high while the queue is non-empty or the FSM is not in IDLE.
- sclk, output, 1, SPI clock; idles low.
- mosi, output, 1, SPI data out.
- ss_n, output, 1, chip select, active low.
- miso, input, 1, SPI data in.
- latch_data, output, 1, one-cycle pulse after each word completes.

Behaviour:
- Reset: while reset_n is low at a clock edge, all state clears.
  - Reset values: sclk=0, mosi=0, ss_n=1, latch_data=0, rsp_valid=0, rsp_data=0, busy=0.
  - The queue empties, so cmd_ready=1.
  - A reset mid-word aborts the word: ss_n returns high, and no latch_data or rsp_valid pulse is produced.
- Queue:
  - FIFO of FIFO_DEPTH entries with wrapping read/write pointers and an occupancy count.
  - cmd_ready = !full and is combinational from the count.
  - A push and a pop in the same cycle leave the count unchanged.
  - A push while full is impossible by handshake.
- FSM states: IDLE, SETUP, HIGH, LOW, LATCH, GAP.
  - A half-period counter counts CLK_DIV-1 down to 0. A bit counter runs from WORD_WIDTH-1 down to 0.
- IDLE:
  - If the queue is non-empty: pop into the shift register, set ss_n=0, drive mosi=word[MSB], go to SETUP.
  - A word pushed into an empty queue is popped on the following cycle.
- SETUP: hold for CLK_DIV cycles with sclk=0, then go to HIGH with sclk=1.
- HIGH:
  - On entry (the rising edge), sample miso into the LSB of the receive register, shifting left.
  - Hold for CLK_DIV cycles, then set sclk=0 and go to LOW.
- LOW:
  - On entry (the falling edge), if bits remain, shift mosi to the next bit.
  - After CLK_DIV cycles: if the bit counter is not 0, decrement it and go to HIGH; otherwise go to LATCH.
  - mosi holds the last bit through LOW.
- LATCH (one cycle):
  - ss_n=1, mosi=0, latch_data=1, rsp_valid=1, rsp_data = receive register.
- GAP:
  - ss_n stays high for CLK_DIV cycles, then go to IDLE.
  - The back-to-back minimum deselect is 1 + CLK_DIV cycles.
- Timing:
  - ss_n is low for exactly CLK_DIV*(1+2*WORD_WIDTH) cycles.
  - With CLK_DIV=2 and WORD_WIDTH=32, ss_n is low for 130 cycles and the latch_data pulse falls on cycle 131 after the pop.
- Bit ordering:
  - MSB is transmitted first.
  - The bit received first ends up in rsp_data[WORD_WIDTH-1].
- latch_data and rsp_valid are never high in consecutive cycles.
- latch_data is never high while ss_n=0.

Optional Feature:
Macro: SPI_TRIGGER_AFTER_LAST_EN.
- Enabled:
  - Adds input cmd_last (1 bit), stored in the FIFO alongside each word.
  - Adds output control_trigger (1 bit, reset value 0).
  - control_trigger pulses for one cycle, in the cycle after LATCH, for a word pushed with cmd_last=1.
  - This starts a sequencer update cycle only after a complete configuration burst.
- Disabled: neither port exists, the FIFO is WORD_WIDTH wide, and no trigger is generated.

Test Plan:
1. Reset, then push 0xA5C3_0F81 with CLK_DIV=2 and miso tied low. Required response:
   - cmd_ready=1 after reset.
   - A bench SPI slave model (sampling mosi on rising sclk) receives 0xA5C30F81.
   - ss_n is low for 130 cycles and sees 32 rising sclk edges.
   - latch_data is high for 1 cycle, and rsp_data=0.
2. miso driven from a slave shift register preloaded with 0x1234_5678, MSB first and changing on falling sclk -> rsp_valid pulses once and rsp_data=0x12345678.
3. Push 5 words back-to-back with FIFO_DEPTH=4 and no stalls in the source. Required response:
   - cmd_ready drops after the 4th queued word and recovers after the first pop.
   - All 5 words are transmitted in order.
   - ss_n is high for 1+CLK_DIV cycles between words.
   - busy falls only after the last GAP.
4. Assert reset_n=0 for 1 cycle at bit 17 of a transfer. Required response:
   - On the next cycle ss_n=1, sclk=0, mosi=0, busy=0.
   - No latch_data or rsp_valid pulse.
   - The queue is empty.
   - A subsequent push transmits cleanly.
5. CLK_DIV=1 with word 0xFFFF_FFFF -> ss_n is low for 65 cycles, mosi stays high throughout, and sclk toggles every cycle.
6. With SPI_TRIGGER_AFTER_LAST_EN, push 3 words with cmd_last=0,0,1 -> exactly one control_trigger pulse, one cycle after the third latch_data pulse.
